// File: rtl/univ_shift_reg_p.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_p
//   Parametrised universal shift register with a burst serialiser.
//   Idle: mode selects HOLD / SHL / SHR / LOAD / ROL / ROR / ASR / CLR, with
//   multi-bit amounts taken from shamt. A start request loads par_in and
//   shifts it out one bit per enabled cycle on ser_out, flagged by busy/done.
//
//   Burst handshake: start is a request that is accepted on any rising edge
//   where en=1 and the block is idle (busy=0). It is ignored while busy=1.
//   Acceptance is visible one cycle later as busy=1. done pulses for one
//   cycle, the cycle busy falls. A new start may be presented in that same
//   done cycle.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   en         in   1        operation enable; 0 holds q and freezes a burst
//   mode       in   3        idle operation select
//   shamt      in   SHAMT_W  shift/rotate amount
//   sl_in      in   1        LSB fill for SHL
//   sr_in      in   1        MSB fill for logical SHR
//   par_in     in   WIDTH    parallel load data (LOAD and burst start)
//   start      in   1        burst request
//   burst_dir  in   1        0 = MSB first (shift left), 1 = LSB first (shift right)
//   q          out  WIDTH    register contents
//   ser_out    out  1        serial bit, q[WIDTH-1] or q[0] per latched direction
//   busy       out  1        burst in progress
//   done       out  1        one-cycle pulse after the last burst shift
// -----------------------------------------------------------------------------
module univ_shift_reg_p #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [2:0]         mode,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               sl_in,
   input  logic               sr_in,
   input  logic [WIDTH-1:0]   par_in,
   input  logic               start,
   input  logic               burst_dir,
   output logic [WIDTH-1:0]   q,
   output logic               ser_out,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [SHAMT_W-1:0] SH_W   = SHAMT_W'(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               dir_q;

   logic [WIDTH-1:0]   q_next;
   logic [SHAMT_W-1:0] sh_clamp;
   logic [SHAMT_W-1:0] sh_rot;
   logic [2*WIDTH-1:0] ext_shl;
   logic [2*WIDTH-1:0] ext_shr;
   logic [2*WIDTH-1:0] ext_asr;
   logic [2*WIDTH-1:0] ext_rol;
   logic [2*WIDTH-1:0] ext_ror;

   // Amounts beyond WIDTH behave exactly like WIDTH (everything is fill), so
   // clamp once and let a double-width shift pull fill bits into place.
   // Rotates reduce the amount modulo WIDTH, which also covers non-power-of-2
   // widths.
   always_comb begin
      sh_clamp = (shamt > SH_W) ? SH_W : shamt;
      sh_rot   = shamt % SH_W;
      ext_shl  = {q, {WIDTH{sl_in}}} << sh_clamp;
      ext_shr  = {{WIDTH{sr_in}}, q} >> sh_clamp;
      ext_asr  = {{WIDTH{q[WIDTH-1]}}, q} >> sh_clamp;
      ext_rol  = {q, q} << sh_rot;
      ext_ror  = {q, q} >> sh_rot;
      q_next   = q;
      case (mode)
         M_HOLD: q_next = q;
         M_SHL:  q_next = ext_shl[2*WIDTH-1 -: WIDTH];
         M_SHR:  q_next = ext_shr[WIDTH-1:0];
         M_LOAD: q_next = par_in;
         M_ROL:  q_next = ext_rol[2*WIDTH-1 -: WIDTH];
         M_ROR:  q_next = ext_ror[WIDTH-1:0];
         M_ASR:  q_next = ext_asr[WIDTH-1:0];
         M_CLR:  q_next = '0;
         default: q_next = q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         q     <= '0;
         cnt   <= '0;
         dir_q <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         // done is a pure one-cycle pulse, cleared even when en=0.
         done <= 1'b0;
         if (en) begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     q     <= par_in;
                     dir_q <= burst_dir;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= ST_SHIFT;
                  end else begin
                     q <= q_next;
                  end
               end
               ST_SHIFT: begin
                  q   <= dir_q ? {1'b0, q[WIDTH-1:1]} : {q[WIDTH-2:0], 1'b0};
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // The serial tap stays on the last latched direction while idle.
   assign ser_out = dir_q ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg_p.sv
module tb_univ_shift_reg_p;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- WIDTH=8 instance ----------------
   logic       en = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [3:0] shamt = '0;
   logic       sl_in = 1'b0;
   logic       sr_in = 1'b0;
   logic [7:0] par_in = '0;
   logic       start = 1'b0;
   logic       burst_dir = 1'b0;
   logic [7:0] q;
   logic       ser_out, busy, done;

   univ_shift_reg_p #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .shamt(shamt),
      .sl_in(sl_in), .sr_in(sr_in), .par_in(par_in), .start(start),
      .burst_dir(burst_dir), .q(q), .ser_out(ser_out), .busy(busy), .done(done)
   );

   // ---------------- WIDTH=5 instance ----------------
   logic       en5 = 1'b0;
   logic [2:0] mode5 = 3'b000;
   logic [3:0] shamt5 = '0;
   logic       sl5 = 1'b0;
   logic [4:0] par5 = '0;
   logic       start5 = 1'b0;
   logic [4:0] q5;
   logic       ser5, busy5, done5;

   univ_shift_reg_p #(.WIDTH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .shamt(shamt5),
      .sl_in(sl5), .sr_in(1'b0), .par_in(par5), .start(start5),
      .burst_dir(1'b0), .q(q5), .ser_out(ser5), .busy(busy5), .done(done5)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       en;
      logic [2:0] mode;
      logic [3:0] shamt;
      logic       sl;
      logic       sr;
      logic [7:0] par;
      logic [7:0] exp_q;
   } vec_t;

   localparam int NV = 29;
   vec_t vecs [NV];

   // ---------------- burst drivers ----------------
   task automatic start_burst(input logic [7:0] d, input logic dir);
      en = 1'b1; start = 1'b1; par_in = d; burst_dir = dir;
      mode = 3'b111;              // start must win over CLR
      step();
      start = 1'b0;
   endtask

   // Walks the WIDTH shifts of a burst that start_burst just launched.
   // noise drives start/par_in while busy; they must be ignored.
   task automatic stream_burst(input string tag, input logic [7:0] d, input logic dir,
                               input int stall_at, input int stall_len, input logic noise);
      int busy_cycles;
      logic [7:0] exp_q;
      logic exp_bit;
      busy_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         exp_q   = dir ? (d >> i) : (d << i);
         exp_bit = dir ? d[i] : d[7-i];
         mode    = 3'b111;
         if (noise) begin start = 1'b1; par_in = 8'hFF; end
         chk({tag, "_busy"}, busy, 1'b1);
         chk({tag, "_ser"}, ser_out, exp_bit);
         chk({tag, "_q"}, q, exp_q);
         chk({tag, "_done_low"}, done, 1'b0);
         if (busy === 1'b1) busy_cycles++;
         if (i == stall_at) begin
            en = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               step();
               chk({tag, "_stall_ser"}, ser_out, exp_bit);
               chk({tag, "_stall_q"}, q, exp_q);
               if (busy === 1'b1) busy_cycles++;
            end
            en = 1'b1;
         end
         step();
      end
      start = 1'b0;
      mode  = 3'b000;
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy_fall"}, busy, 1'b0);
      chk({tag, "_q_end"}, q, 8'h00);
      chk({tag, "_busy_len"}, busy_cycles, 8 + stall_len);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vecs[0]  = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'h96, 8'h96};
      vecs[1]  = '{1'b1, 3'b001, 4'd3,  1'b1, 1'b0, 8'h00, 8'hB7};
      vecs[2]  = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'h96, 8'h96};
      vecs[3]  = '{1'b1, 3'b010, 4'd2,  1'b0, 1'b0, 8'h00, 8'h25};
      vecs[4]  = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'h96, 8'h96};
      vecs[5]  = '{1'b1, 3'b101, 4'd9,  1'b0, 1'b0, 8'h00, 8'h4B};
      vecs[6]  = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'h96, 8'h96};
      vecs[7]  = '{1'b1, 3'b110, 4'd8,  1'b0, 1'b0, 8'h00, 8'hFF};
      vecs[8]  = '{1'b1, 3'b111, 4'd0,  1'b0, 1'b0, 8'h00, 8'h00};
      vecs[9]  = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'hA5, 8'hA5};
      vecs[10] = '{1'b1, 3'b001, 4'd0,  1'b1, 1'b1, 8'h00, 8'hA5};
      vecs[11] = '{1'b1, 3'b010, 4'd0,  1'b1, 1'b1, 8'h00, 8'hA5};
      vecs[12] = '{1'b1, 3'b100, 4'd0,  1'b0, 1'b0, 8'h00, 8'hA5};
      vecs[13] = '{1'b1, 3'b101, 4'd0,  1'b0, 1'b0, 8'h00, 8'hA5};
      vecs[14] = '{1'b1, 3'b110, 4'd0,  1'b0, 1'b0, 8'h00, 8'hA5};
      vecs[15] = '{1'b1, 3'b000, 4'd3,  1'b1, 1'b1, 8'h00, 8'hA5};
      vecs[16] = '{1'b1, 3'b100, 4'd3,  1'b0, 1'b0, 8'h00, 8'h2D};
      vecs[17] = '{1'b1, 3'b001, 4'd9,  1'b0, 1'b0, 8'h00, 8'h00};
      vecs[18] = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'h3C, 8'h3C};
      vecs[19] = '{1'b1, 3'b010, 4'd12, 1'b0, 1'b1, 8'h00, 8'hFF};
      vecs[20] = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'h81, 8'h81};
      vecs[21] = '{1'b1, 3'b110, 4'd3,  1'b0, 1'b0, 8'h00, 8'hF0};
      vecs[22] = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'h81, 8'h81};
      vecs[23] = '{1'b1, 3'b010, 4'd3,  1'b0, 1'b0, 8'h00, 8'h10};
      vecs[24] = '{1'b0, 3'b011, 4'd0,  1'b0, 1'b0, 8'h55, 8'h10};
      vecs[25] = '{1'b1, 3'b001, 4'd8,  1'b1, 1'b0, 8'h00, 8'hFF};
      vecs[26] = '{1'b1, 3'b011, 4'd0,  1'b0, 1'b0, 8'h01, 8'h01};
      vecs[27] = '{1'b1, 3'b100, 4'd9,  1'b0, 1'b0, 8'h00, 8'h02};
      vecs[28] = '{1'b1, 3'b101, 4'd10, 1'b0, 1'b0, 8'h00, 8'h80};

      // Reset state
      repeat (2) step();
      chk("rst_q", q, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ser", ser_out, 1'b0);
      rst_n = 1'b1;
      step();

      // Asynchronous reset between edges after LOAD A5
      en = 1'b1; mode = 3'b011; par_in = 8'hA5;
      step();
      mode = 3'b000;
      chk("pre_rst_q", q, 8'hA5);
      chk("pre_rst_ser", ser_out, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_q", q, 8'h00);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_done", done, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_done", done, 1'b0);

      // Mode vectors
      for (int i = 0; i < NV; i++) begin
         en = vecs[i].en; mode = vecs[i].mode; shamt = vecs[i].shamt;
         sl_in = vecs[i].sl; sr_in = vecs[i].sr; par_in = vecs[i].par;
         step();
         chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
         chk($sformatf("vec%0d_busy", i), busy, 1'b0);
      end
      en = 1'b1; mode = 3'b000; shamt = '0;

      // Burst C3 MSB first, start/par_in noise while busy
      start_burst(8'hC3, 1'b0);
      stream_burst("b1", 8'hC3, 1'b0, -1, 0, 1'b1);
      step();
      chk("b1_done_pulse", done, 1'b0);
      chk("b1_idle_busy", busy, 1'b0);

      // Burst 2D LSB first with a 3-cycle stall, then back-to-back 0F
      start_burst(8'h2D, 1'b1);
      stream_burst("b2", 8'h2D, 1'b1, 3, 3, 1'b0);
      start_burst(8'h0F, 1'b0);   // issued in the done cycle
      stream_burst("b3", 8'h0F, 1'b0, -1, 0, 1'b0);
      step();
      chk("b3_done_pulse", done, 1'b0);
      chk("b3_idle_q", q, 8'h00);

      // Reset mid-burst: abort with no done pulse
      start_burst(8'h5A, 1'b0);
      mode = 3'b000;
      step();
      step();
      chk("mid_busy", busy, 1'b1);
      chk("mid_q", q, 8'h68);     // 5A shifted left twice
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_q", q, 8'h00);
      chk("mid_rst_busy", busy, 1'b0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_rst_no_done", done, 1'b0);
         chk("mid_rst_idle", busy, 1'b0);
      end

      // WIDTH=5 instance: rotate modulo a non-power-of-2 width
      en5 = 1'b1; mode5 = 3'b011; par5 = 5'b10011;
      step();
      chk("w5_load", q5, 5'b10011);
      mode5 = 3'b100; shamt5 = 4'd7;
      step();
      chk("w5_rol7", q5, 5'b01110);
      mode5 = 3'b011;
      step();
      mode5 = 3'b100; shamt5 = 4'd2;
      step();
      chk("w5_rol2", q5, 5'b01110);
      mode5 = 3'b011;
      step();
      mode5 = 3'b101; shamt5 = 4'd7;
      step();
      chk("w5_ror7", q5, 5'b11100);
      mode5 = 3'b001; shamt5 = 4'd5; sl5 = 1'b1;
      step();
      chk("w5_shl5", q5, 5'b11111);
      chk("w5_ser", ser5, 1'b1);
      chk("w5_busy", busy5, 1'b0);
      chk("w5_done", done5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
